// File: rtl/xbar_ingress_queue.sv
// xbar_ingress_queue: per-input-port store-and-forward packet buffer for the
// 4x4 crossbar. Buffers whole packets, raises a one-hot request toward the
// head packet's destination arbiter, and streams the packet once granted.
// After each packet, grants are masked for HOLDOFF cycles to cover the
// arbiter's registered grant latency.
// Optional feature macro: XBAR_IQ_STATS_EN (enables the pkt_sent counter).
module xbar_ingress_queue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_dest,
  output logic [3:0]        request,
  input  logic [3:0]        grant,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_dest,
  output logic [15:0]       pkt_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int EW = DATA_W + 4;
  localparam logic [AW:0]   LP_DEPTH     = (AW + 1)'(DEPTH);
  localparam logic [HW-1:0] LP_HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One-hot decode of a destination port index.
  function automatic logic [3:0] f_onehot(input logic [1:0] dest);
    logic [3:0] v;
    v = 4'b0001 << dest;
    return v;
  endfunction

  // Storage and pointers. Entry layout: {dest[1:0], sop, eop, data}.
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       r_pkt_cnt;
  logic [1:0]        r_cur_dest;

  // Control.
  state_t            r_state;
  state_t            w_state_nxt;
  logic [HW-1:0]     r_hold_cnt;
  logic [HW-1:0]     w_hold_nxt;
  logic [3:0]        r_request;
  logic [3:0]        w_req_nxt;

  // Output word registers.
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sop;
  logic              r_out_eop;
  logic [1:0]        r_out_dest;

  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_head;
  logic [1:0]        w_head_dest;
  logic              w_head_sop;
  logic              w_head_eop;
  logic [1:0]        w_wr_dest;
  logic              w_pkt_inc;
  logic              w_pkt_dec;

  assign in_ready    = (r_count < LP_DEPTH);
  assign w_push      = in_valid && in_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_dest = w_head[DATA_W+3:DATA_W+2];
  assign w_head_sop  = w_head[DATA_W+1];
  assign w_head_eop  = w_head[DATA_W];
  // The sop word carries its own dest; later words reuse the latched one.
  assign w_wr_dest   = in_sop ? in_dest : r_cur_dest;
  assign w_pkt_inc   = w_push && in_eop;
  assign w_pkt_dec   = w_pop && w_head_eop;

  assign request   = r_request;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sop   = r_out_sop;
  assign out_eop   = r_out_eop;
  assign out_dest  = r_out_dest;

  // Write the incoming word into the buffer memory (no reset needed on data).
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_wr_dest, in_sop, in_eop, in_data};
    end
  end

  // Pointers, occupancy, latched packet destination.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cur_dest <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && in_sop) begin
        r_cur_dest <= in_dest;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count of complete packets held in the buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt <= '0;
    end else begin
      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + (AW + 1)'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - (AW + 1)'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Next-state, pop decision, request and hold-off counter.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_request;
    w_hold_nxt  = r_hold_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_nxt = 4'b0000;
        if (r_pkt_cnt != '0) begin
          w_state_nxt = ST_REQ;
          w_req_nxt   = f_onehot(w_head_dest);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Only the grant bit of the head packet's destination matters.
        if (grant[w_head_dest] && (r_count != '0)) begin
          w_pop = 1'b1;
          if (w_head_eop) begin
            w_state_nxt = ST_HOLD;
            w_req_nxt   = 4'b0000;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = ST_XFER;
          end
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_XFER: begin
        // Whole packet is resident, so one word per cycle is always available.
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_head_eop) begin
            w_state_nxt = ST_HOLD;
            w_req_nxt   = 4'b0000;
            w_hold_nxt  = '0;
          end else begin
            w_state_nxt = ST_XFER;
          end
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_HOLD: begin
        w_req_nxt = 4'b0000;
        if (r_hold_cnt == LP_HOLD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 4'b0000;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // FSM state, request and hold-off counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_request  <= 4'b0000;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_request  <= w_req_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Output registers carry the popped entry for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_dest  <= 2'd0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head[DATA_W-1:0];
      r_out_sop   <= w_head_sop;
      r_out_eop   <= w_head_eop;
      r_out_dest  <= w_head_dest;
    end else begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_dest  <= 2'd0;
    end
  end

`ifdef XBAR_IQ_STATS_EN
  logic [15:0] r_pkt_sent;

  // Transmitted-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_sent <= 16'd0;
    end else if (w_pkt_dec) begin
      r_pkt_sent <= r_pkt_sent + 16'd1;
    end else begin
      r_pkt_sent <= r_pkt_sent;
    end
  end

  assign pkt_sent = r_pkt_sent;
`else
  assign pkt_sent = 16'd0;
`endif

endmodule

// File: tb/tb_xbar_ingress_queue.sv
// Self-checking bench for xbar_ingress_queue. Expected output words are queued
// when the bench drives them in and compared when the DUT emits them.
module tb_xbar_ingress_queue;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int HOLDOFF = 3;

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [1:0]        in_dest;
  logic [3:0]        request;
  logic [3:0]        grant;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [1:0]        out_dest;
  logic [15:0]       pkt_sent;

  int          checks;
  int          errors;
  logic [15:0] exp_sent;
  logic [35:0] q[$];

  xbar_ingress_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_dest  (in_dest),
    .request  (request),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_dest (out_dest),
    .pkt_sent (pkt_sent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and compare any emitted word with the scoreboard.
  task automatic tick();
    logic [35:0] exp;
    logic [35:0] got;
    @(posedge clock);
    #1;
    if (reset_n && out_valid) begin
      checks++;
      got = {out_dest, out_sop, out_eop, out_data};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_word: unexpected word %h, scoreboard empty", got);
      end else begin
        exp = q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL out_word: got %h expected %h", got, exp);
        end
`ifdef XBAR_IQ_STATS_EN
        if (exp[32]) exp_sent = exp_sent + 16'd1;
`endif
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    q.delete();
    exp_sent = 16'd0;
  endtask

  // Drive one packet, waiting for in_ready on each word.
  task automatic send_pkt(input logic [1:0] dest, input int len, input logic [31:0] base,
                          input bit with_eop, input bit track);
    logic acc;
    int   n;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      in_sop   = (i == 0);
      in_eop   = with_eop && (i == len - 1);
      in_dest  = (i == 0) ? dest : ~dest;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
        acc = in_ready;
        tick();
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: word %0d not accepted, in_ready=%b expected 1", i, in_ready);
      end else if (track) begin
        q.push_back({dest, (i == 0) ? 1'b1 : 1'b0, (with_eop && (i == len - 1)) ? 1'b1 : 1'b0, base + 32'(i)});
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_request();
    int n;
    n = 0;
    while (request == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (request == 4'b0000) begin
      errors++;
      $display("FAIL request_timeout: request=%b expected nonzero", request);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      tick();
      if (q.size() == 0 && request == 4'b0000 && !out_valid && in_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: %0d words pending, request=%b expected empty/0", name, q.size(), request);
    end
    for (int n = 0; n < 6; n++) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (request !== 4'b0000)   begin errors++; $display("FAIL rst_request: got %b expected 0000", request); end
    checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if ({out_sop, out_eop} !== 2'b00) begin errors++; $display("FAIL rst_framing: got %b expected 00", {out_sop, out_eop}); end
    checks++; if (out_data !== 32'd0 || out_dest !== 2'd0) begin errors++; $display("FAIL rst_data: got %h/%0d expected 0/0", out_data, out_dest); end
    checks++; if (pkt_sent !== 16'd0)    begin errors++; $display("FAIL rst_pkt_sent: got %0d expected 0", pkt_sent); end
  endtask

  task automatic test_single();
    grant = 4'b0000;
    send_pkt(2'd2, 4, 32'h0000_1000, 1'b1, 1'b1);
    checks++; if (request !== 4'b0000) begin errors++; $display("FAIL single_req_early: got %b expected 0000", request); end
    tick();
    checks++; if (request !== 4'b0100) begin errors++; $display("FAIL single_req: got %b expected 0100", request); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (request !== 4'b0100 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_wait: request=%b out_valid=%b expected 0100/0", request, out_valid);
      end
    end
    grant = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || request !== ((k == 3) ? 4'b0000 : 4'b0100)) begin
        errors++;
        $display("FAIL single_xfer%0d: out_valid=%b request=%b expected 1/%b", k, out_valid, request,
                 (k == 3) ? 4'b0000 : 4'b0100);
      end
    end
    grant = 4'b0000;
    tick();
    checks++;
    if ({out_valid, out_sop, out_eop} !== 3'b000) begin
      errors++;
      $display("FAIL single_after: valid/sop/eop=%b expected 000", {out_valid, out_sop, out_eop});
    end
    checks++; if (pkt_sent !== exp_sent) begin errors++; $display("FAIL single_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent); end
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    logic       ov [16];
    logic [3:0] rq [16];
    logic [1:0] od [16];
    int i_pop;
    int i_req;
    int bad;
    grant = 4'b1111;
    send_pkt(2'd0, 1, 32'h0000_2000, 1'b1, 1'b1);
    send_pkt(2'd3, 1, 32'h0000_2100, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      tick();
      ov[i] = out_valid;
      rq[i] = request;
      od[i] = out_dest;
    end
    i_pop = -1;
    i_req = -1;
    for (int i = 0; i < 16; i++) if (i_pop < 0 && ov[i] && od[i] == 2'd0) i_pop = i;
    for (int i = 0; i < 16; i++) if (i_req < 0 && i_pop >= 0 && i > i_pop && rq[i] == 4'b1000) i_req = i;
    checks++;
    if (i_pop < 0 || i_req < 0 || (i_req - i_pop) != HOLDOFF + 1) begin
      errors++;
      $display("FAIL b2b_holdoff: second request %0d edges after eop pop expected %0d", i_req - i_pop, HOLDOFF + 1);
    end
    bad = 0;
    if (i_pop >= 0 && i_req >= 0) begin
      for (int i = i_pop + 1; i <= i_req; i++) if (ov[i]) bad++;
      for (int i = i_pop; i < i_req; i++) if (rq[i] != 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_hold_quiet: %0d active cycles during hold expected 0", bad);
    end
    grant = 4'b0000;
    wait_drain("b2b");
  endtask

  task automatic test_wrong_grant();
    int bad;
    grant = 4'b0010;
    send_pkt(2'd0, 1, 32'h0000_3000, 1'b1, 1'b1);
    wait_request();
    checks++; if (request !== 4'b0001) begin errors++; $display("FAIL wrong_grant_req: got %b expected 0001", request); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (request !== 4'b0001 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrong_grant_hold: %0d bad cycles expected 0", bad);
    end
    grant = 4'b0001;
    wait_drain("wrong_grant");
    grant = 4'b0000;
  endtask

  task automatic test_fill();
    grant = 4'b0000;
    send_pkt(2'd1, DEPTH, 32'h0000_4000, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    grant = 4'b0010;
    send_pkt(2'd3, 4, 32'h0000_4100, 1'b1, 1'b1);
    grant = 4'b1010;
    wait_drain("fill");
    grant = 4'b0000;
    checks++; if (pkt_sent !== exp_sent) begin errors++; $display("FAIL fill_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent); end
  endtask

  task automatic test_partial();
    int bad;
    grant = 4'b1111;
    send_pkt(2'd2, 3, 32'h0000_5000, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (request !== 4'b0000 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL partial_idle: %0d active cycles expected 0", bad);
    end
    grant = 4'b0000;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL partial_reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    grant = 4'b0000;
    send_pkt(2'd1, 5, 32'h0000_6000, 1'b1, 1'b1);
    wait_request();
    checks++; if (request !== 4'b0010) begin errors++; $display("FAIL mid_req: got %b expected 0010", request); end
    grant = 4'b0010;
    tick();
    checks++; if (out_valid !== 1'b1 || out_sop !== 1'b1) begin errors++; $display("FAIL mid_word1: valid/sop=%b%b expected 11", out_valid, out_sop); end
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_sop, out_eop} !== 3'b000 || out_data !== 32'd0 || request !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_out: valid/sop/eop=%b data=%h request=%b expected 000/0/0000",
               {out_valid, out_sop, out_eop}, out_data, request);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", in_ready); end
    checks++; if (pkt_sent !== 16'd0) begin errors++; $display("FAIL mid_reset_sent: got %0d expected 0", pkt_sent); end
    q.delete();
    exp_sent = 16'd0;
    grant = 4'b0000;
    tick();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    send_pkt(2'd2, 3, 32'h0000_7000, 1'b1, 1'b1);
    wait_request();
    checks++; if (request !== 4'b0100) begin errors++; $display("FAIL mid_fresh_req: got %b expected 0100", request); end
    grant = 4'b0100;
    wait_drain("mid_fresh");
    grant = 4'b0000;
    checks++; if (pkt_sent !== exp_sent) begin errors++; $display("FAIL mid_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_sent = 16'd0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_dest  = 2'd0;
    grant    = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrong_grant();
    test_fill();
    test_partial();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbar_ingress_queue.md
# xbar_ingress_queue

Per-input-port packet buffer of the 4x4 crossbar, sitting directly upstream of the round-robin output arbiters. It stores incoming packets store-and-forward, raises a one-hot request toward the arbiter of the head packet's destination output, and streams the packet into the crossbar datapath once that arbiter grants it. After each packet it masks stale grants for a programmable hold-off, because the arbiter's grant lags its request through a registered pipeline.

## Interface
- DATA_W, 32, payload word width
- DEPTH, 16, FIFO depth in words (power of two, ≥4); also the maximum packet length
- HOLDOFF, 3, cycles after a packet's last word during which grants are ignored (≥1)
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  queue can accept a word
- in_data  input  DATA_W  payload word
- in_sop  input  1  first word of packet
- in_eop  input  1  last word of packet
- in_dest  input  2  destination output port; sampled only on the sop word
- request  output  4  one-hot request, bit d goes to output d's arbiter
- grant  input  4  bit d is this port's grant bit from output d's arbiter
- out_valid  output  1  word valid into the crossbar
- out_data  output  DATA_W  payload word
- out_sop / out_eop  output  1 each  packet framing
- out_dest  output  2  destination of the current word
- pkt_sent  output  16  count of packets fully transmitted (see Configuration)

## Operation
- FIFO entries hold {dest, sop, eop, data}. The sop word's dest is latched and stored with every word of that packet.
- in_ready = (count < DEPTH). A push occurs when in_valid && in_ready. There is no bypass; a full FIFO never pushes.
- pkt_cnt counts complete packets in the FIFO:
  - +1 on a push with eop.
  - −1 on a pop with eop.
  - Both in the same cycle leaves it unchanged.
- Upstream must not send packets longer than DEPTH words. A sop without a preceding eop is undefined.
- FSM:
  - IDLE: request = 0. Go to REQ when pkt_cnt > 0.
  - REQ: request = onehot(head.dest). When grant[head.dest] is sampled high, pop the head word and go to XFER. Grant bits for other destinations are ignored.
  - XFER: request is held. Pop one word per cycle; there is no backpressure from the crossbar. The pop of the eop word moves to HOLD and clears request at that edge.
  - HOLD: request = 0, grant ignored. A counter runs HOLDOFF cycles, then returns to IDLE.
- Output registers load the popped entry. out_valid = 1 exactly in cycles following a pop; otherwise out_valid = 0 and out_sop/out_eop = 0.
- A single-word packet (sop = eop) goes REQ → HOLD directly.
- Reset, asserted at any time including mid-packet: FIFO empty, pkt_cnt = 0, state IDLE. All outputs 0 except in_ready = 1. The partially sent packet is abandoned.

## Timing
- A push of the eop word at edge t makes pkt_cnt > 0 after t. IDLE → REQ occurs at t+1, and request is high after t+1.
- With grant sampled high at edge g: the first word has out_valid high after g. The last word of an N-word packet has out_valid after g+N−1, and request falls at that same edge.
- The next request can rise no earlier than HOLDOFF+1 edges after the eop pop.
- in_ready updates the cycle after the count changes. The FIFO never overflows or underflows.

## Configuration
- XBAR_IQ_STATS_EN defined: pkt_sent increments on each eop pop and wraps from 0xFFFF to 0. It resets to 0.
- Not defined: pkt_sent is tied to 0 and no counter is synthesized.

## Test plan
- Single 4-word packet, dest = 2; grant[2] asserted 3 cycles after request → request = 4'b0100. Words appear on 4 consecutive cycles with sop on the first and eop on the fourth. request = 0 after eop. pkt_sent = 1 with the macro.
- grant = 4'b1111 held permanently, two back-to-back 1-word packets to dest 0 and dest 3 → second request (4'b1000) rises exactly HOLDOFF+1 cycles after the first eop pop. No word is sent during HOLD.
- grant[1] high while head dest = 0 → no pop, request stays 4'b0001.
- Fill with a 16-word packet → in_ready = 0 at count 16. Pop and push in the same cycle while draining → pkt_cnt correct; no lost or duplicated word.
- Partial packet (sop, no eop) written → request stays 0 indefinitely.
- reset_n pulsed low during word 2 of a 5-word XFER → outputs clear immediately, in_ready = 1. A following fresh packet is sent intact.
